// File: rtl/link_return_ctrl_if.sv
// Execute-stage redirect requests into the fetch controller, and the PC/LR/flush results
// coming back out of it.
interface link_return_ctrl_if;
  logic        link_back_i;
  logic [15:0] lr_i;
  logic        bl_i;
  logic [15:0] bl_pc_i;
  logic [15:0] bl_target_i;
  logic        stall_i;
  logic [15:0] pc_o;
  logic        lr_wr_en_o;
  logic [15:0] lr_wr_data_o;
  logic        flush_o;
  logic        redirect_o;

  modport master (
    output link_back_i, lr_i, bl_i, bl_pc_i, bl_target_i, stall_i,
    input  pc_o, lr_wr_en_o, lr_wr_data_o, flush_o, redirect_o
  );

  modport slave (
    input  link_back_i, lr_i, bl_i, bl_pc_i, bl_target_i, stall_i,
    output pc_o, lr_wr_en_o, lr_wr_data_o, flush_o, redirect_o
  );
endinterface

// File: rtl/link_return_ctrl.sv
// Fetch PC sequencer. It handles BL (branch-and-link) and link-back (PC <- LR) redirects,
// then squashes the pipeline for a fixed window after each redirect.
module link_return_ctrl #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  link_return_ctrl_if.slave    bus
);

  typedef enum logic {RUN, FLUSH} state_e;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_e      state_q,    state_d;
  logic [1:0]  cnt_q,      cnt_d;
  logic [15:0] pc_q,       pc_d;
  logic        lr_en_q,    lr_en_d;
  logic [15:0] lr_data_q,  lr_data_d;
  logic        flush_q,    flush_d;
  logic        redirect_q, redirect_d;
  logic        take;

  // Every output is derived from next-state values so that it lands registered,
  // one edge after the request that caused it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    lr_en_d    = 1'b0;
    lr_data_d  = lr_data_q;
    flush_d    = 1'b0;
    redirect_d = 1'b0;
    take       = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.link_back_i) begin
          pc_d = {bus.lr_i[15:1], 1'b0};
          take = 1'b1;
        end else if (bus.bl_i) begin
          pc_d      = {bus.bl_target_i[15:1], 1'b0};
          lr_en_d   = 1'b1;
          lr_data_d = bus.bl_pc_i + 16'd2;
          take      = 1'b1;
        end else if (!bus.stall_i) begin
          pc_d = pc_q + 16'd2;
        end

        if (take) begin
          state_d    = FLUSH;
          cnt_d      = FLUSH_LOAD;
          flush_d    = 1'b1;
          redirect_d = 1'b1;
        end
      end

      FLUSH: begin
        // Requests seen here belong to squashed instructions and are dropped.
        if (!bus.stall_i) begin
          pc_d = pc_q + 16'd2;
        end
        if (cnt_q == 2'd0) begin
          state_d = RUN;
        end else begin
          cnt_d   = cnt_q - 2'd1;
          flush_d = 1'b1;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      cnt_q      <= 2'd0;
      pc_q       <= RESET_PC;
      lr_en_q    <= 1'b0;
      lr_data_q  <= 16'h0000;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      lr_en_q    <= lr_en_d;
      lr_data_q  <= lr_data_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.lr_wr_en_o   = lr_en_q;
  assign bus.lr_wr_data_o = lr_data_q;
  assign bus.flush_o      = flush_q;
  assign bus.redirect_o   = redirect_q;

endmodule
